sig_delay_capture: RTL and testbench

Sample-writer counterpart to the sine ROM readers: accepts an 8-bit signal stream (microphone/Vbuddy input), writes it into a circular dual-port RAM, and reads back the sample written `offset` samples earlier. Used as a variable delay line and capture buffer beside the sine generators. Tracks fill level so a delayed sample is never read before it has actually been written.

---
 rtl/sig_pkg.sv | 6 +
 rtl/dual_port_ram.sv | 20 ++
 rtl/sig_delay_capture.sv | 70 +++++++
 tb/tb_sig_delay_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// sig_pkg: shared widths and fill-state encoding for the signal capture buffer.
package sig_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 9;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_t;
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: one synchronous write port and one registered read port, array not reset.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sig_delay_capture.sv
// sig_delay_capture: circular capture buffer returning the sample written offset samples ago.
module sig_delay_capture
    import sig_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] mic_signal,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0] delayed_signal,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  full
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    fill_state_t           state, state_n;
    logic [ADDR_WIDTH-1:0] base_addr, rd_addr;
    logic [ADDR_WIDTH:0]   base_fill, fill_n;
    logic                  valid, bypass, sel_bypass;
    logic [DATA_WIDTH-1:0] bypass_data, ram_data;

    // clr restarts the buffer in the same cycle, so an accompanying sample lands at address 0
    always_comb begin
        base_addr = clr ? '0 : wr_addr;
        base_fill = clr ? '0 : fill_level;
        valid     = en && ({1'b0, offset} <= base_fill);
        bypass    = valid && (offset == '0);
        rd_addr   = base_addr - offset;
        fill_n    = (en && !(state == FULL && !clr)) ? base_fill + 1'b1 : base_fill;
        state_n   = fill_n == '0 ? EMPTY : fill_n == DEPTH ? FULL : FILLING;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            wr_addr     <= '0;
            fill_level  <= '0;
            dout_valid  <= 1'b0;
            sel_bypass  <= 1'b1;
            bypass_data <= '0;
        end else begin
            state      <= state_n;
            wr_addr    <= en ? base_addr + 1'b1 : base_addr;
            fill_level <= fill_n;
            dout_valid <= valid;
            if (valid) sel_bypass <= bypass;
            if (bypass) bypass_data <= mic_signal;
        end
    end

    // Both sources only load on valid cycles, so the selected one holds across invalid ones
    assign delayed_signal = sel_bypass ? bypass_data : ram_data;
    assign full           = state == FULL;

    dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .we      (en),
        .wr_addr (base_addr),
        .wr_data (mic_signal),
        .re      (valid && !bypass),
        .rd_addr (rd_addr),
        .rd_data (ram_data)
    );
endmodule

// File: tb/tb_sig_delay_capture.sv
// tb_sig_delay_capture: directed vector table plus hand-written wrap, clr and reset sequences.
module tb_sig_delay_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] mic_signal = '0;
    logic [8:0] offset = '0;
    logic [7:0] delayed_signal;
    logic       dout_valid;
    logic [8:0] wr_addr;
    logic [9:0] fill_level;
    logic       full;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic       clr;
        logic [8:0] offset;
        logic [7:0] mic;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [8:0] exp_wr;
        logic [9:0] exp_fill;
    } vec_t;

    vec_t vecs[$];

    sig_delay_capture dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .clr            (clr),
        .mic_signal     (mic_signal),
        .offset         (offset),
        .delayed_signal (delayed_signal),
        .dout_valid     (dout_valid),
        .wr_addr        (wr_addr),
        .fill_level     (fill_level),
        .full           (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic c, input int off, input int m,
                       input logic v, input int d, input int w, input int f);
        vec_t x;
        x.en = e; x.clr = c; x.offset = 9'(off); x.mic = 8'(m);
        x.exp_valid = v; x.exp_data = 8'(d); x.exp_wr = 9'(w); x.exp_fill = 10'(f);
        vecs.push_back(x);
    endtask

    task automatic drive(input logic e, input logic c, input int off, input int m);
        en = e; clr = c; offset = 9'(off); mic_signal = 8'(m);
        step();
    endtask

    initial begin
        add(1, 0, 0, 'h10, 1, 'h10, 1, 1);
        add(1, 0, 0, 'h11, 1, 'h11, 2, 2);
        add(1, 0, 0, 'h12, 1, 'h12, 3, 3);
        add(0, 0, 0, 'hff, 0, 'h12, 3, 3);
        add(0, 1, 0, 'h00, 0, 'h12, 0, 0);
        add(1, 0, 3, 0, 0, 'h12, 1, 1);
        add(1, 0, 3, 1, 0, 'h12, 2, 2);
        add(1, 0, 3, 2, 0, 'h12, 3, 3);
        add(1, 0, 3, 3, 1, 0, 4, 4);
        add(1, 0, 3, 4, 1, 1, 5, 5);
        add(1, 0, 3, 5, 1, 2, 6, 6);
        add(1, 0, 1, 'h20, 1, 5, 7, 7);
        add(0, 0, 1, 'hee, 0, 5, 7, 7);
        add(1, 0, 1, 'h21, 1, 'h20, 8, 8);
        add(0, 0, 1, 'hee, 0, 'h20, 8, 8);
        add(1, 0, 1, 'h22, 1, 'h21, 9, 9);
        add(1, 1, 0, 'h30, 1, 'h30, 1, 1);
        add(1, 0, 2, 'h31, 0, 'h30, 2, 2);
        add(1, 0, 2, 'h32, 1, 'h30, 3, 3);
        add(1, 0, 2, 'h33, 1, 'h31, 4, 4);
        add(1, 0, 2, 'h34, 1, 'h32, 5, 5);
        add(1, 0, 2, 'h35, 1, 'h33, 6, 6);
        add(1, 0, 10, 'h36, 0, 'h33, 7, 7);
        add(1, 0, 10, 'h37, 0, 'h33, 8, 8);
        add(1, 0, 10, 'h38, 0, 'h33, 9, 9);
        add(1, 0, 10, 'h39, 0, 'h33, 10, 10);
        add(1, 0, 10, 'h3a, 1, 'h30, 11, 11);
        add(1, 1, 5, 'h40, 0, 'h30, 1, 1);

        #12;
        chk("reset_data", delayed_signal, 0);
        chk("reset_valid", dout_valid, 0);
        chk("reset_wr", wr_addr, 0);
        chk("reset_fill", fill_level, 0);
        chk("reset_full", full, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].offset, vecs[i].mic);
            chk($sformatf("v%0d_valid", i), dout_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_data", i), delayed_signal, vecs[i].exp_data);
            chk($sformatf("v%0d_wr", i), wr_addr, vecs[i].exp_wr);
            chk($sformatf("v%0d_fill", i), fill_level, vecs[i].exp_fill);
            chk($sformatf("v%0d_full", i), full, 0);
        end

        drive(0, 1, 0, 0);
        for (int k = 0; k < 600; k++) begin
            drive(1, 0, 511, k % 256);
            if (k == 510) begin
                chk("wrap_510_valid", dout_valid, 0);
                chk("wrap_510_wr", wr_addr, 511);
                chk("wrap_510_full", full, 0);
            end
            if (k == 511) begin
                chk("wrap_511_valid", dout_valid, 1);
                chk("wrap_511_data", delayed_signal, 0);
                chk("wrap_511_wr", wr_addr, 0);
                chk("wrap_511_full", full, 1);
                chk("wrap_511_fill", fill_level, 512);
            end
            if (k == 520) begin
                chk("wrap_520_data", delayed_signal, 9);
                chk("wrap_520_fill", fill_level, 512);
            end
        end
        drive(0, 0, 0, 0);
        chk("full_idle_valid", dout_valid, 0);
        drive(1, 0, 100, 'h77);
        chk("full_offset_change_valid", dout_valid, 1);
        chk("full_offset_change_data", delayed_signal, (599 - 99) % 256);

        drive(1, 1, 0, 'hab);
        chk("clr_en_full_valid", dout_valid, 1);
        chk("clr_en_full_data", delayed_signal, 'hab);
        chk("clr_en_full_fill", fill_level, 1);
        chk("clr_en_full_wr", wr_addr, 1);
        chk("clr_en_full_full", full, 0);
        for (int k = 0; k < 511; k++) drive(1, 0, 300, k);
        chk("refill_full", full, 1);
        drive(1, 1, 5, 'hcd);
        chk("clr_en_off5_valid", dout_valid, 0);
        chk("clr_en_off5_fill", fill_level, 1);
        chk("clr_en_off5_wr", wr_addr, 1);

        drive(0, 1, 0, 0);
        for (int k = 0; k < 20; k++) drive(1, 0, 3, 'h60 + k);
        chk("pre_reset_valid", dout_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_data", delayed_signal, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_wr", wr_addr, 0);
        chk("midrst_fill", fill_level, 0);
        chk("midrst_full", full, 0);
        en = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 3, 'h50 + k);
            chk($sformatf("postrst_%0d_valid", k), dout_valid, k == 3 ? 1 : 0);
        end
        chk("postrst_data", delayed_signal, 'h50);
        drive(0, 0, 3, 0);
        chk("postrst_pulse_end", dout_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
